writeback_checker: RTL and testbench
====================================

Name: writeback_checker

Overview:
- Synthesisable self-check monitor that sits beside processor_top and snoops the register-file writeback port (reg_write, rd, rd_data, pc).
- Holds shadow copies of up to NUM_CHECKS architectural registers and compares them against expected values when the run ends.
- Records every writeback in a trace FIFO.
- Reports done/pass, a per-check fail mask and a watchdog timeout, so checking runs both in simulation and on FPGA over the debug path.

Parameters:
- DATA_W, 32, data and PC width
- REG_ADDR_W, 5, register index width
- NUM_CHECKS, 4, number of expected-value check slots
- TRACE_DEPTH, 16, trace FIFO entries (power of two, ≥2)
- MAX_CYCLES, 1024, watchdog limit in RUN cycles

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches expectations and arms the run
- halt  in  1  one-cycle pulse; ends the run normally
- wb_valid  in  1  register write enable from writeback
- wb_rd  in  REG_ADDR_W  destination register
- wb_data  in  DATA_W  value written
- wb_pc  in  DATA_W  PC of the committing instruction
- exp_en  in  NUM_CHECKS  slot i enabled
- exp_addr  in  NUM_CHECKS*REG_ADDR_W  slot i register index, packed with slot 0 in the LSBs
- exp_data  in  NUM_CHECKS*DATA_W  slot i expected value, packed the same way
- trace_rd_en  in  1  pop the trace FIFO
- trace_valid  out  1  FIFO not empty
- trace_data  out  2*DATA_W+REG_ADDR_W  head entry {pc, rd, data}, show-ahead
- trace_overflow  out  1  sticky: an entry was dropped
- busy  out  1  state is RUN or CHECK
- done  out  1  state is DONE
- pass  out  1  valid while done
- fail_mask  out  NUM_CHECKS  per-slot failure, valid while done
- timeout  out  1  watchdog expired, valid while done

Behaviour:
- Reset (reset=0, asynchronous) state:
  - state=IDLE; FIFO empty; pointers and all flags 0.
  - Outputs: trace_valid=0, trace_data=0, trace_overflow=0, busy=0, done=0, pass=0, fail_mask=0, timeout=0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE, on start → RUN:
  - Latch exp_en, exp_addr and exp_data into internal copies; inputs may then change freely.
  - Clear seen[], shadow[], cycle counter, timeout, fail_mask and trace_overflow. The FIFO contents are kept.
- RUN, each cycle:
  - cycle counter increments.
  - If wb_valid and wb_rd≠0: every enabled slot with addr==wb_rd sets seen=1 and shadow=wb_data; the last write wins.
  - Writes to x0 update no slot but are still traced.
  - RUN → CHECK on halt. Also → CHECK when the counter reaches MAX_CYCLES-1; this sets timeout=1.
  - If halt and wb_valid occur in the same cycle, that writeback is applied before the transition.
- CHECK (exactly 1 cycle):
  - fail_mask[i] = en[i] & (!seen[i] | shadow[i]≠data[i]). Disabled slots never fail.
  - → DONE.
- DONE:
  - done=1; pass = (fail_mask==0) & !timeout.
  - Results hold until start, which behaves as it does in IDLE and goes to RUN.
- start is ignored in RUN and CHECK. halt is ignored outside RUN.
- Latency: done rises 2 cycles after the halt edge (halt sampled → CHECK → DONE).
- Trace FIFO:
  - Push on wb_valid in RUN only.
  - Full and no pop: the entry is dropped and trace_overflow is set (sticky until next start).
  - Full with simultaneous pop: push and pop both succeed, no overflow.
  - Empty with pop: ignored. Pointers wrap modulo TRACE_DEPTH.
  - trace_data shows the head combinationally from registered storage.
- Reset mid-run aborts immediately to the reset state; no partial results are visible.

Decomposition:
- Package wb_check_pkg: the FSM state encoding, the trace-entry width function, and the slot field-extraction helpers for packed exp_addr/exp_data.
- One sub-module: trace_fifo, a parametrised synchronous FIFO with full/empty, simultaneous push/pop and drop-on-full reporting.

Test Plan:
- Baseline program (slots x1=0x1E, x4=0x0F), writes x2=0x0F, x3=0x0F, x1=0x1E, x4=0x0F, then halt → done 2 cycles later, pass=1, fail_mask=0, 4 trace entries in order with correct {pc,rd,data}.
- Same program but x4 written 0x10 → pass=0, fail_mask=4'b0010.
- Slot x3 enabled and x3 never written → fail_mask bit set for that slot (missing write), pass=0.
- No halt, MAX_CYCLES=16 → timeout=1 at cycle 16 of RUN, done=1, pass=0 even with all slots matching.
- TRACE_DEPTH=4:
  - 6 writebacks with no pops → 4 entries held (the first 4), trace_overflow=1.
  - Rerun with a pop on the 5th writeback → trace_overflow stays 0.
- Assert reset mid-RUN after 2 writebacks → all outputs 0 immediately. A new start and rerun gives the baseline results, and x0 writes never set any slot.

Source files
------------

// File: rtl/wb_check_pkg.sv
// Shared types and helpers for the writeback self-check monitor.
// FSM encoding, trace entry sizing and packed slot field offsets.
package wb_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int trace_w(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

    // LSB of slot idx inside a packed per-slot vector of field width w
    function automatic int slot_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/writeback_checker_trace_fifo.sv
// Synchronous FIFO holding writeback trace entries.
// Drops pushes when full unless a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_checker.sv
// Writeback snooper: shadows selected registers, checks them at halt,
// traces every writeback and guards the run with a watchdog.
module writeback_checker
    import wb_check_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_CHECKS  = 4,
    parameter int TRACE_DEPTH = 16,
    parameter int MAX_CYCLES  = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             halt,
    input  logic                             wb_valid,
    input  logic [REG_ADDR_W-1:0]            wb_rd,
    input  logic [DATA_W-1:0]                wb_data,
    input  logic [DATA_W-1:0]                wb_pc,
    input  logic [NUM_CHECKS-1:0]            exp_en,
    input  logic [NUM_CHECKS*REG_ADDR_W-1:0] exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0]     exp_data,
    input  logic                             trace_rd_en,
    output logic                             trace_valid,
    output logic [2*DATA_W+REG_ADDR_W-1:0]   trace_data,
    output logic                             trace_overflow,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [NUM_CHECKS-1:0]            fail_mask,
    output logic                             timeout
);

    localparam int ENTRY_W = trace_w(DATA_W, REG_ADDR_W);
    localparam int CNT_W   = $clog2(MAX_CYCLES) + 1;

    state_t state;
    state_t state_nx;

    logic [NUM_CHECKS-1:0] en_q;
    logic [REG_ADDR_W-1:0] addr_in [NUM_CHECKS];
    logic [DATA_W-1:0]     data_in [NUM_CHECKS];
    logic [REG_ADDR_W-1:0] addr_q  [NUM_CHECKS];
    logic [DATA_W-1:0]     data_q  [NUM_CHECKS];
    logic [DATA_W-1:0]     shadow  [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] seen;
    logic [NUM_CHECKS-1:0] fail_nx;
    logic [CNT_W-1:0]      cycles;

    logic start_ok;
    logic in_run;
    logic at_limit;
    logic wb_hit;
    logic fifo_empty;
    logic fifo_drop;
    logic [ENTRY_W-1:0] entry;

    assign in_run   = (state == ST_RUN);
    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign at_limit = (cycles == CNT_W'(MAX_CYCLES - 1));
    assign wb_hit   = in_run && wb_valid && (wb_rd != '0);
    assign entry    = {wb_pc, wb_rd, wb_data};

    always_comb begin
        for (int i = 0; i < NUM_CHECKS; i++) begin
            addr_in[i] = exp_addr[slot_lsb(i, REG_ADDR_W) +: REG_ADDR_W];
            data_in[i] = exp_data[slot_lsb(i, DATA_W) +: DATA_W];
        end
    end

    always_comb begin
        fail_nx = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            fail_nx[i] = en_q[i] & (!seen[i] | (shadow[i] != data_q[i]));
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (halt || at_limit) state_nx = ST_CHECK;
            ST_CHECK: state_nx = ST_DONE;
            ST_DONE:  if (start) state_nx = ST_RUN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q           <= '0;
            seen           <= '0;
            cycles         <= '0;
            timeout        <= 1'b0;
            fail_mask      <= '0;
            trace_overflow <= 1'b0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                shadow[i] <= '0;
            end
        end else begin
            if (start_ok) begin
                en_q           <= exp_en;
                seen           <= '0;
                cycles         <= '0;
                timeout        <= 1'b0;
                fail_mask      <= '0;
                trace_overflow <= 1'b0;
                for (int i = 0; i < NUM_CHECKS; i++) begin
                    addr_q[i] <= addr_in[i];
                    data_q[i] <= data_in[i];
                    shadow[i] <= '0;
                end
            end
            if (in_run) begin
                cycles <= cycles + 1'b1;
                if (at_limit) begin
                    timeout <= 1'b1;
                end
            end
            // x0 never matches because wb_hit excludes it
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (wb_hit && en_q[i] && addr_q[i] == wb_rd) begin
                    seen[i]   <= 1'b1;
                    shadow[i] <= wb_data;
                end
            end
            if (state == ST_CHECK) begin
                fail_mask <= fail_nx;
            end
            if (fifo_drop) begin
                trace_overflow <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk   (clk),
        .reset (reset),
        .push  (in_run && wb_valid),
        .pop   (trace_rd_en),
        .din   (entry),
        .head  (trace_data),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign trace_valid = !fifo_empty;
    assign busy        = (state == ST_RUN) || (state == ST_CHECK);
    assign done        = (state == ST_DONE);
    assign pass        = done && (fail_mask == '0) && !timeout;

endmodule

// File: tb/tb_writeback_checker.sv
// Directed self-checking bench for writeback_checker.
// Small trace depth and watchdog so edge cases are reached quickly.
module tb_writeback_checker;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NC = 4;
    localparam int TD = 4;
    localparam int MC = 16;
    localparam int EW = 2 * DW + AW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           halt;
    logic           wb_valid;
    logic [AW-1:0]  wb_rd;
    logic [DW-1:0]  wb_data;
    logic [DW-1:0]  wb_pc;
    logic [NC-1:0]  exp_en;
    logic [NC*AW-1:0] exp_addr;
    logic [NC*DW-1:0] exp_data;
    logic           trace_rd_en;
    logic           trace_valid;
    logic [EW-1:0]  trace_data;
    logic           trace_overflow;
    logic           busy;
    logic           done;
    logic           pass;
    logic [NC-1:0]  fail_mask;
    logic           timeout;

    int passed = 0;
    int total  = 0;
    logic [EW-1:0] exp_q [$];

    writeback_checker #(
        .DATA_W      (DW),
        .REG_ADDR_W  (AW),
        .NUM_CHECKS  (NC),
        .TRACE_DEPTH (TD),
        .MAX_CYCLES  (MC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .halt           (halt),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_pc          (wb_pc),
        .exp_en         (exp_en),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .trace_rd_en    (trace_rd_en),
        .trace_valid    (trace_valid),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_mask      (fail_mask),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slots(input logic [NC-1:0] en,
                             input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                             input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        exp_en   = en;
        exp_addr = {5'd0, a2, a1, a0};
        exp_data = {32'h0, d2, d1, d0};
    endtask

    task automatic do_start();
        exp_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        // scramble inputs to prove they were latched
        exp_en   = '0;
        exp_addr = '1;
        exp_data = '1;
    endtask

    task automatic wr(input logic [AW-1:0] rd, input logic [DW-1:0] d,
                      input logic [DW-1:0] pc, input logic pop);
        wb_valid    = 1'b1;
        wb_rd       = rd;
        wb_data     = d;
        wb_pc       = pc;
        trace_rd_en = pop;
        exp_q.push_back({pc, rd, d});
        step();
        wb_valid    = 1'b0;
        trace_rd_en = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        step();
        halt = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && trace_valid; i++) begin
            trace_rd_en = 1'b1;
            step();
            trace_rd_en = 1'b0;
        end
    endtask

    task automatic baseline_slots();
        set_slots(4'b0011, 5'd1, 32'h1E, 5'd4, 32'h0F, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        logic [EW+7:0] got;
        logic [EW+7:0] want;
        got  = {trace_valid, trace_data, trace_overflow, busy, done,
                pass, fail_mask, timeout} ;
        want = '0;
        total++;
        if (got !== want) $display("FAIL reset_outputs got %h exp %h", got, want);
        else passed++;
    endtask

    task automatic test_baseline(input string tag);
        baseline_slots();
        do_start();
        total++;
        if (busy !== 1'b1) $display("FAIL %s_busy got %b exp 1", tag, busy);
        else passed++;
        wr(5'd2, 32'h0F, 32'h100, 1'b0);
        wr(5'd3, 32'h0F, 32'h104, 1'b0);
        wr(5'd1, 32'h1E, 32'h108, 1'b0);
        wr(5'd4, 32'h0F, 32'h10C, 1'b0);
        do_halt();
        total++;
        if (done !== 1'b0) $display("FAIL %s_done_early got %b exp 0", tag, done);
        else passed++;
        step();
        total++;
        if ({done, pass, fail_mask} !== {1'b1, 1'b1, 4'b0000})
            $display("FAIL %s_result got d%b p%b m%b exp d1 p1 m0000",
                     tag, done, pass, fail_mask);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (trace_valid !== 1'b1 || trace_data !== exp_q[i])
                $display("FAIL %s_trace%0d got v%b %h exp v1 %h",
                         tag, i, trace_valid, trace_data, exp_q[i]);
            else passed++;
            trace_rd_en = 1'b1;
            step();
            trace_rd_en = 1'b0;
        end
        total++;
        if (trace_valid !== 1'b0) $display("FAIL %s_empty got %b exp 0", tag, trace_valid);
        else passed++;
    endtask

    task automatic test_mismatch();
        baseline_slots();
        do_start();
        wr(5'd2, 32'h0F, 32'h200, 1'b0);
        wr(5'd3, 32'h0F, 32'h204, 1'b0);
        wr(5'd1, 32'h1E, 32'h208, 1'b0);
        wr(5'd4, 32'h10, 32'h20C, 1'b0);
        do_halt();
        step();
        total++;
        if ({done, pass, fail_mask} !== {1'b1, 1'b0, 4'b0010})
            $display("FAIL mismatch got d%b p%b m%b exp d1 p0 m0010",
                     done, pass, fail_mask);
        else passed++;
        drain();
    endtask

    task automatic test_missing_write();
        set_slots(4'b0111, 5'd1, 32'h1E, 5'd4, 32'h0F, 5'd3, 32'h0F);
        do_start();
        wr(5'd2, 32'h0F, 32'h300, 1'b0);
        wr(5'd1, 32'h1E, 32'h304, 1'b0);
        wr(5'd4, 32'h0F, 32'h308, 1'b0);
        do_halt();
        step();
        total++;
        if ({done, pass, fail_mask} !== {1'b1, 1'b0, 4'b0100})
            $display("FAIL missing got d%b p%b m%b exp d1 p0 m0100",
                     done, pass, fail_mask);
        else passed++;
        drain();
    endtask

    task automatic test_timeout();
        baseline_slots();
        do_start();
        wr(5'd1, 32'h1E, 32'h400, 1'b0);
        wr(5'd4, 32'h0F, 32'h404, 1'b0);
        repeat (MC - 3) step();
        total++;
        if ({busy, timeout, done} !== 3'b100)
            $display("FAIL timeout_last_run got b%b t%b d%b exp b1 t0 d0",
                     busy, timeout, done);
        else passed++;
        step();
        total++;
        if ({busy, timeout, done} !== 3'b110)
            $display("FAIL timeout_check got b%b t%b d%b exp b1 t1 d0",
                     busy, timeout, done);
        else passed++;
        step();
        total++;
        if ({done, pass, timeout, fail_mask} !== {1'b1, 1'b0, 1'b1, 4'b0000})
            $display("FAIL timeout_done got d%b p%b t%b m%b exp d1 p0 t1 m0000",
                     done, pass, timeout, fail_mask);
        else passed++;
        drain();
    endtask

    task automatic test_overflow();
        baseline_slots();
        do_start();
        for (int i = 0; i < 6; i++)
            wr(5'(i + 5), 32'hA0 + i, 32'h500 + 4 * i, 1'b0);
        total++;
        if (trace_overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", trace_overflow);
        else passed++;
        do_halt();
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (trace_valid !== 1'b1 || trace_data !== exp_q[i])
                $display("FAIL ovf_trace%0d got v%b %h exp v1 %h",
                         i, trace_valid, trace_data, exp_q[i]);
            else passed++;
            trace_rd_en = 1'b1;
            step();
            trace_rd_en = 1'b0;
        end
        total++;
        if (trace_valid !== 1'b0) $display("FAIL ovf_empty got %b exp 0", trace_valid);
        else passed++;
        baseline_slots();
        do_start();
        total++;
        if (trace_overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", trace_overflow);
        else passed++;
        for (int i = 0; i < 5; i++)
            wr(5'(i + 5), 32'hB0 + i, 32'h600 + 4 * i, i == 4);
        total++;
        if (trace_overflow !== 1'b0) $display("FAIL ovf_pop got %b exp 0", trace_overflow);
        else passed++;
        total++;
        if (trace_data !== exp_q[1])
            $display("FAIL ovf_pop_head got %h exp %h", trace_data, exp_q[1]);
        else passed++;
        do_halt();
        step();
        drain();
    endtask

    task automatic test_mid_reset();
        baseline_slots();
        do_start();
        wr(5'd1, 32'h1E, 32'h700, 1'b0);
        wr(5'd4, 32'h0F, 32'h704, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        test_reset();
        step();
        reset = 1'b1;
        step();
        test_baseline("rerun");
        set_slots(4'b0111, 5'd1, 32'h1E, 5'd4, 32'h0F, 5'd0, 32'hDEAD);
        do_start();
        wr(5'd0, 32'hDEAD, 32'h800, 1'b0);
        wr(5'd1, 32'h1E, 32'h804, 1'b0);
        wr(5'd4, 32'h0F, 32'h808, 1'b0);
        wr(5'd0, 32'hDEAD, 32'h80C, 1'b0);
        do_halt();
        step();
        total++;
        if ({done, pass, fail_mask} !== {1'b1, 1'b0, 4'b0100})
            $display("FAIL x0_slot got d%b p%b m%b exp d1 p0 m0100",
                     done, pass, fail_mask);
        else passed++;
        total++;
        if (trace_data !== exp_q[0])
            $display("FAIL x0_traced got %h exp %h", trace_data, exp_q[0]);
        else passed++;
        drain();
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        halt        = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        wb_pc       = '0;
        exp_en      = '0;
        exp_addr    = '0;
        exp_data    = '0;
        trace_rd_en = 1'b0;
        #1;
        test_reset();
        step();
        reset = 1'b1;
        step();
        test_baseline("base");
        test_mismatch();
        test_missing_write();
        test_timeout();
        test_overflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
